// File: rtl/display_sched.sv
// Display source scheduler: shows the background digits, or one of two requested
// messages held for HOLD_CYCLES, with the alert (req[1]) taking priority.
module display_sched #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bg_val,
  input  logic [3:0]  bg_dp,
  input  logic [1:0]  req,
  input  logic [15:0] val1,
  input  logic [3:0]  dp1,
  input  logic [15:0] val2,
  input  logic [3:0]  dp2,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out,
  output logic [1:0]  src,
  output logic        busy
);

  // Handshake: req[k] is a level held until ack[k] pulses; the value is latched on
  // that same edge, and req[k] seen while ack[k] is high is the stale request and ignored.
  typedef enum logic [1:0] {
    SHOW_BG = 2'd0,
    SHOW_R0 = 2'd1,
    SHOW_R1 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      disp;

  logic [1:0] req_eff;
  logic       expire;
  logic       preempt;
  logic       arb_slot;
  logic       do_grant;
  logic       end_dwell;

  always_comb begin
    req_eff   = req & ~ack;
    expire    = (state != SHOW_BG) && (cnt == '0);
    preempt   = (state == SHOW_R0) && !expire && req_eff[1];
    // Full arbitration only while idle or at dwell expiry; mid-dwell only the alert may cut in.
    arb_slot  = (state == SHOW_BG) || expire;
    do_grant  = arb_slot ? (|req_eff) : preempt;
    end_dwell = expire || preempt;
  end

  // The state encoding doubles as the source indicator and exposes the FSM state.
  assign src  = state;
  assign hex3 = disp[15:12];
  assign hex2 = disp[11:8];
  assign hex1 = disp[7:4];
  assign hex0 = disp[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= SHOW_BG;
      cnt    <= '0;
      disp   <= '0;
      dp_out <= '0;
      ack    <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      ack  <= '0;
      done <= '0;
      if (end_dwell) done <= (state == SHOW_R1) ? 2'b10 : 2'b01;
      if (do_grant) begin
        cnt  <= CNT_W'(HOLD_CYCLES - 1);
        busy <= 1'b1;
        if (req_eff[1]) begin
          state  <= SHOW_R1;
          ack    <= 2'b10;
          disp   <= val2;
          dp_out <= dp2;
        end else begin
          state  <= SHOW_R0;
          ack    <= 2'b01;
          disp   <= val1;
          dp_out <= dp1;
        end
      end else if (arb_slot) begin
        state  <= SHOW_BG;
        disp   <= bg_val;
        dp_out <= bg_dp;
        busy   <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_sched.sv
// Directed bench for display_sched with an 8-cycle dwell.
module tb_display_sched;

  logic        clk;
  logic        reset_n;
  logic [15:0] bg_val;
  logic [3:0]  bg_dp;
  logic [1:0]  req;
  logic [15:0] val1;
  logic [3:0]  dp1;
  logic [15:0] val2;
  logic [3:0]  dp2;
  logic [1:0]  ack;
  logic [1:0]  done;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic [3:0]  dp_out;
  logic [1:0]  src;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  display_sched #(.HOLD_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bg_val(bg_val), .bg_dp(bg_dp), .req(req),
    .val1(val1), .dp1(dp1), .val2(val2), .dp2(dp2), .ack(ack), .done(done),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out),
    .src(src), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // packed as {hex[15:0], dp[3:0], src[1:0], busy, ack[1:0], done[1:0]}
  task automatic check(input string tag, input logic [15:0] e_hex, input logic [3:0] e_dp,
                       input logic [1:0] e_src, input logic e_busy, input logic [1:0] e_ack,
                       input logic [1:0] e_done);
    logic [26:0] obs;
    logic [26:0] exp_v;
    obs   = {hex3, hex2, hex1, hex0, dp_out, src, busy, ack, done};
    exp_v = {e_hex, e_dp, e_src, e_busy, e_ack, e_done};
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed hex=%h dp=%b src=%0d busy=%b ack=%b done=%b expected hex=%h dp=%b src=%0d busy=%b ack=%b done=%b",
             tag, obs[26:11], obs[10:7], obs[6:5], obs[4], obs[3:2], obs[1:0],
             e_hex, e_dp, e_src, e_busy, e_ack, e_done);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bg_val = '0; bg_dp = '0; req = '0;
    val1 = '0; dp1 = '0; val2 = '0; dp2 = '0;
    #1;
    check("reset", 16'h0000, 4'b0000, 2'd0, 1'b0, 2'b00, 2'b00);
    step();
    step();
    reset_n = 1'b1;

    // background follows with one cycle of latency
    bg_val = 16'h1234; bg_dp = 4'b0001;
    step();
    check("bg_1234", 16'h1234, 4'b0001, 2'd0, 1'b0, 2'b00, 2'b00);

    // single req[0] dwell, background changes underneath
    req = 2'b01; val1 = 16'hABCD; dp1 = 4'b1010;
    step();
    check("r0_ack", 16'hABCD, 4'b1010, 2'd1, 1'b1, 2'b01, 2'b00);
    req = 2'b00; bg_val = 16'h9999; val1 = 16'h1111; dp1 = 4'b1111;
    for (int i = 1; i < 8; i++) begin
      step();
      check("r0_dwell", 16'hABCD, 4'b1010, 2'd1, 1'b1, 2'b00, 2'b00);
    end
    step();
    check("r0_done_bg", 16'h9999, 4'b0001, 2'd0, 1'b0, 2'b00, 2'b01);

    // simultaneous requests: alert first, then pending UART
    req = 2'b11; val1 = 16'h5678; dp1 = 4'b0011; val2 = 16'hEEEE; dp2 = 4'b0100;
    step();
    check("both_ack1", 16'hEEEE, 4'b0100, 2'd2, 1'b1, 2'b10, 2'b00);
    req = 2'b01;
    for (int i = 1; i < 8; i++) begin
      step();
      check("both_r1_dwell", 16'hEEEE, 4'b0100, 2'd2, 1'b1, 2'b00, 2'b00);
    end
    step();
    check("done1_ack0", 16'h5678, 4'b0011, 2'd1, 1'b1, 2'b01, 2'b10);
    req = 2'b00;
    for (int i = 1; i < 8; i++) begin
      step();
      check("both_r0_dwell", 16'h5678, 4'b0011, 2'd1, 1'b1, 2'b00, 2'b00);
    end
    step();
    check("both_end_bg", 16'h9999, 4'b0001, 2'd0, 1'b0, 2'b00, 2'b01);

    // preemption three cycles into a req[0] dwell
    req = 2'b01; val1 = 16'h1357; dp1 = 4'b0110;
    step();
    check("pre_ack0", 16'h1357, 4'b0110, 2'd1, 1'b1, 2'b01, 2'b00);
    req = 2'b00;
    step();
    check("pre_r0_c2", 16'h1357, 4'b0110, 2'd1, 1'b1, 2'b00, 2'b00);
    step();
    check("pre_r0_c3", 16'h1357, 4'b0110, 2'd1, 1'b1, 2'b00, 2'b00);
    req = 2'b10; val2 = 16'h2468; dp2 = 4'b1001;
    step();
    check("pre_done0_ack1", 16'h2468, 4'b1001, 2'd2, 1'b1, 2'b10, 2'b01);
    req = 2'b00;
    for (int i = 1; i < 8; i++) begin
      step();
      check("pre_r1_dwell", 16'h2468, 4'b1001, 2'd2, 1'b1, 2'b00, 2'b00);
    end
    step();
    check("pre_end_bg", 16'h9999, 4'b0001, 2'd0, 1'b0, 2'b00, 2'b10);

    // alert re-requested during its own dwell: back-to-back re-grant
    req = 2'b10; val2 = 16'hCAFE; dp2 = 4'b1100;
    step();
    check("rr_ack1", 16'hCAFE, 4'b1100, 2'd2, 1'b1, 2'b10, 2'b00);
    req = 2'b00;
    for (int i = 1; i < 5; i++) begin
      step();
      check("rr_dwell_a", 16'hCAFE, 4'b1100, 2'd2, 1'b1, 2'b00, 2'b00);
    end
    req = 2'b10; val2 = 16'hBEEF; dp2 = 4'b0111;
    for (int i = 5; i < 8; i++) begin
      step();
      check("rr_dwell_b", 16'hCAFE, 4'b1100, 2'd2, 1'b1, 2'b00, 2'b00);
    end
    step();
    check("rr_done1_ack1", 16'hBEEF, 4'b0111, 2'd2, 1'b1, 2'b10, 2'b10);
    req = 2'b00;
    for (int i = 1; i < 8; i++) begin
      step();
      check("rr_dwell_c", 16'hBEEF, 4'b0111, 2'd2, 1'b1, 2'b00, 2'b00);
    end
    step();
    check("rr_end_bg", 16'h9999, 4'b0001, 2'd0, 1'b0, 2'b00, 2'b10);

    // asynchronous reset mid-dwell with req[0] still held
    req = 2'b01; val1 = 16'h4321; dp1 = 4'b0101;
    step();
    check("rst_ack0", 16'h4321, 4'b0101, 2'd1, 1'b1, 2'b01, 2'b00);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", 16'h0000, 4'b0000, 2'd0, 1'b0, 2'b00, 2'b00);
    step();
    check("rst_held", 16'h0000, 4'b0000, 2'd0, 1'b0, 2'b00, 2'b00);
    reset_n = 1'b1;
    val1 = 16'h7777; dp1 = 4'b1000;
    step();
    check("rst_regrant", 16'h7777, 4'b1000, 2'd1, 1'b1, 2'b01, 2'b00);
    req = 2'b00;
    step();
    check("rst_dwell", 16'h7777, 4'b1000, 2'd1, 1'b1, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
